// File: rtl/branch_predictor_gshare_if.sv
// Branch predictor bundle between the pipeline and branch_predictor_gshare.
//   Fetch side : pc_F, pc4_F in; pc_next, taken_F, idx_F out.
//   Execute    : branch_E, jump_E, branch, taken_E, idx_E, pc_E, pc4_E,
//                pc_target, pc_D in; flush, pc_restore out.
//   Counters   : perf_ctrl, perf_miss out.
// The pipeline side uses the master modport, the predictor the slave one.
interface branch_predictor_gshare_if #(
  parameter int IDX = 10
);
  logic [31:0]    pc_F;
  logic [31:0]    pc4_F;
  logic [31:0]    pc_next;
  logic           taken_F;
  logic [IDX-1:0] idx_F;

  logic           branch_E;
  logic           jump_E;
  logic           branch;
  logic           taken_E;
  logic [IDX-1:0] idx_E;
  logic [31:0]    pc_E;
  logic [31:0]    pc4_E;
  logic [31:0]    pc_target;
  logic [31:0]    pc_D;
  logic           flush;
  logic [31:0]    pc_restore;

  logic [31:0]    perf_ctrl;
  logic [31:0]    perf_miss;

  modport master (
    output pc_F, pc4_F, branch_E, jump_E, branch, taken_E, idx_E,
           pc_E, pc4_E, pc_target, pc_D,
    input  pc_next, taken_F, idx_F, flush, pc_restore, perf_ctrl, perf_miss
  );

  modport slave (
    input  pc_F, pc4_F, branch_E, jump_E, branch, taken_E, idx_E,
           pc_E, pc4_E, pc_target, pc_D,
    output pc_next, taken_F, idx_F, flush, pc_restore, perf_ctrl, perf_miss
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Next-PC predictor: tagged BTB plus 2-bit-counter PHT indexed either by
// PC (MODE=0, bimodal) or PC xor global history (MODE=1, gshare).
// Predicts combinationally in IF, resolves in EX (flush + restore PC) and
// counts resolved control instructions and mispredicts.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bp   : branch_predictor_gshare_if.slave (fetch, execute, counters)
// Constraints: ENTRIES power of two, TAG_BITS + log2(ENTRIES) + 2 <= 32,
// GHR_BITS <= log2(ENTRIES).
module branch_predictor_gshare #(
  parameter int ENTRIES  = 1024,
  parameter int TAG_BITS = 8,
  parameter int GHR_BITS = 10,
  parameter int MODE     = 1
) (
  input logic                      clk,
  input logic                      rst,
  branch_predictor_gshare_if.slave bp
);
  localparam int IDX = $clog2(ENTRIES);

  // Table storage
  logic                btb_valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag_q    [ENTRIES];
  logic [31:0]         btb_target_q [ENTRIES];
  logic                btb_jump_q   [ENTRIES];
  logic [1:0]          pht_q        [ENTRIES];

  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         perf_ctrl_q, perf_ctrl_d;
  logic [31:0]         perf_miss_q, perf_miss_d;

  // Fetch-side decode
  logic [IDX-1:0]      bidx_f, idx_f;
  logic [TAG_BITS-1:0] tag_f;
  logic                hit_f, taken_f;

  // Execute-side decode
  logic [IDX-1:0]      bidx_e;
  logic [TAG_BITS-1:0] tag_e;
  logic                res, actual, mispredict;
  logic                pht_we, btb_we;
  logic [1:0]          pht_d;

  // PC bits outside the index/tag fields carry no information here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.pc_F, bp.pc_E};

  assign bidx_f = bp.pc_F[IDX+1:2];
  assign tag_f  = bp.pc_F[TAG_BITS+IDX+1:IDX+2];
  assign bidx_e = bp.pc_E[IDX+1:2];
  assign tag_e  = bp.pc_E[TAG_BITS+IDX+1:IDX+2];

  // ---------------------------------------------------------------------
  // Prediction (IF): reads the table state as of the start of the cycle,
  // so a same-cycle resolve write is not visible until the next cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path can leave it unassigned and infer a latch.
    idx_f   = bidx_f;
    hit_f   = 1'b0;
    taken_f = 1'b0;

    if (MODE != 0) begin
      idx_f = bidx_f ^ IDX'(ghr_q);
    end

    hit_f   = btb_valid_q[bidx_f] && (btb_tag_q[bidx_f] == tag_f);
    // Jumps are always taken once in the BTB; branches follow the counter MSB.
    taken_f = hit_f && (btb_jump_q[bidx_f] || pht_q[idx_f][1]);
  end

  assign bp.taken_F = taken_f;
  assign bp.idx_F   = idx_f;
  assign bp.pc_next = taken_f ? btb_target_q[bidx_f] : bp.pc4_F;

  // ---------------------------------------------------------------------
  // Resolution (EX) and next-state computation
  // ---------------------------------------------------------------------
  always_comb begin
    res         = bp.branch_E || bp.jump_E;
    actual      = bp.jump_E || bp.branch;
    // A taken prediction to the wrong target is also a mispredict: pc_D is
    // what was actually fetched after this instruction.
    mispredict  = res && ((bp.taken_E != actual) ||
                          (actual && (bp.pc_D != bp.pc_target)));

    pht_we      = bp.branch_E;
    btb_we      = res && actual;

    pht_d       = pht_q[bp.idx_E];
    if (bp.branch && (pht_d != 2'b11)) begin
      pht_d = pht_d + 2'd1;
    end else if (!bp.branch && (pht_d != 2'b00)) begin
      pht_d = pht_d - 2'd1;
    end

    // Shift in the newest outcome at bit 0; the cast drops the oldest bit.
    ghr_d       = bp.branch_E ? GHR_BITS'({ghr_q, bp.branch}) : ghr_q;
    perf_ctrl_d = perf_ctrl_q + {31'd0, res};
    perf_miss_d = perf_miss_q + {31'd0, mispredict};
  end

  assign bp.flush      = mispredict;
  assign bp.pc_restore = actual ? bp.pc_target : bp.pc4_E;
  assign bp.perf_ctrl  = perf_ctrl_q;
  assign bp.perf_miss  = perf_miss_q;

  // ---------------------------------------------------------------------
  // State with reset: valid bits, counters, history, perf counters.
  // A resolve coinciding with reset is dropped.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      ghr_q       <= '0;
      perf_ctrl_q <= '0;
      perf_miss_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid_q[i] <= 1'b0;
        pht_q[i]       <= 2'b01;
      end
    end else begin
      ghr_q       <= ghr_d;
      perf_ctrl_q <= perf_ctrl_d;
      perf_miss_q <= perf_miss_d;
      if (pht_we) begin
        pht_q[bp.idx_E] <= pht_d;
      end
      if (btb_we) begin
        btb_valid_q[bidx_e] <= 1'b1;
      end
    end
  end

  // NOTE: BTB payload (tag/target/kind) is not reset; it is only ever read
  // behind a valid bit, so keeping it out of reset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && btb_we) begin
      btb_tag_q[bidx_e]    <= tag_e;
      btb_target_q[bidx_e] <= bp.pc_target;
      btb_jump_q[bidx_e]   <= bp.jump_E;
    end
  end
endmodule
